stc1_egress_framer: RTL

STC1_EGRESS_FRAMER -- requirements
Module: stc1_egress_framer

---
 rtl/stc1_egress_framer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stc1_egress_framer.sv
// rtl/stc1_egress_framer.sv - buffers complex-sample beats and serialises them into header/sequence/payload byte frames
module stc1_egress_framer #(
    parameter int         DATA_WIDTH = 16,
    parameter int         NUM_LANES  = 2,
    parameter int         FIFO_DEPTH = 16,
    parameter int         FRAME_LEN  = 8,
    parameter logic [7:0] HDR_BYTE   = 8'hA5,
    localparam int        W          = NUM_LANES * 2 * DATA_WIDTH,
    localparam int        BPB        = W / 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Enable,
    input  logic [W-1:0] IngressData,
    input  logic         IngressValid,
    output logic         IngressReady,
    output logic [7:0]   ED,
    output logic         EValid,
    input  logic         EReady,
    output logic [15:0]  FrameCount,
    output logic         Busy
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam int         BLW     = $clog2(BPB + 1);
    localparam logic [AW:0]  PTR_ONE = (AW + 1)'(1);
    localparam logic [BLW-1:0] BL_ONE  = BLW'(1);
    localparam logic [BLW-1:0] BL_LOAD = BLW'(BPB - 1);
    localparam logic [7:0]   FL8     = 8'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        SEQ,
        PAYLOAD
    } state_t;

    logic [W-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [W-1:0]   head;

    state_t         state;
    logic [W-1:0]   sreg;
    logic [BLW-1:0] bytes_left;
    logic [7:0]     beat_cnt;

    logic           accept;
    logic           advance;
    logic           beat_done;
    logic           need_beat;
    logic           frame_done;

    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty        = (wr_ptr == rd_ptr);
    assign IngressReady = !full;
    assign push         = IngressValid && !full;
    assign head         = mem[rd_ptr[AW-1:0]];
    assign Busy         = (state != IDLE);

    // advance: the output register is free to take a new byte this cycle
    assign accept     = EValid && EReady;
    assign advance    = !EValid || EReady;
    assign beat_done  = (state == PAYLOAD) && advance && (bytes_left == '0);
    assign need_beat  = ((state == SEQ) && accept) || (beat_done && (beat_cnt != FL8));
    assign frame_done = beat_done && (beat_cnt == FL8);
    assign pop        = need_beat && !empty;

    always_ff @(posedge Clk) begin
        if (!Rst && push) begin
            mem[wr_ptr[AW-1:0]] <= IngressData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ED         <= 8'h00;
            EValid     <= 1'b0;
            FrameCount <= 16'h0000;
            sreg       <= '0;
            bytes_left <= '0;
            beat_cnt   <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case (state)
                IDLE: begin
                    if (Enable && !empty) begin
                        state  <= HDR;
                        ED     <= HDR_BYTE;
                        EValid <= 1'b1;
                    end
                end

                HDR: begin
                    if (accept) begin
                        state <= SEQ;
                        ED    <= FrameCount[7:0];
                    end
                end

                SEQ: begin
                    if (accept) begin
                        state <= PAYLOAD;
                        if (pop) begin
                            ED         <= head[W-1 -: 8];
                            sreg       <= {head[W-9:0], 8'h00};
                            bytes_left <= BL_LOAD;
                            beat_cnt   <= 8'd1;
                            EValid     <= 1'b1;
                        end else begin
                            bytes_left <= '0;
                            beat_cnt   <= 8'd0;
                            EValid     <= 1'b0;
                        end
                    end
                end

                PAYLOAD: begin
                    if (advance) begin
                        if (bytes_left != '0) begin
                            ED         <= sreg[W-1 -: 8];
                            sreg       <= {sreg[W-9:0], 8'h00};
                            bytes_left <= bytes_left - BL_ONE;
                            EValid     <= 1'b1;
                        end else if (!frame_done) begin
                            // next beat is due; stall with EValid low until the FIFO has it
                            if (pop) begin
                                ED         <= head[W-1 -: 8];
                                sreg       <= {head[W-9:0], 8'h00};
                                bytes_left <= BL_LOAD;
                                beat_cnt   <= beat_cnt + 8'd1;
                                EValid     <= 1'b1;
                            end else begin
                                EValid <= 1'b0;
                            end
                        end else begin
                            FrameCount <= FrameCount + 16'd1;
                            if (Enable && !empty) begin
                                state  <= HDR;
                                ED     <= HDR_BYTE;
                                EValid <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                EValid <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    EValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
